wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 139 +++++++++++++
 tb/tb_wb_regfile.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: general-purpose register file fed by the MEM/WB writeback
// triple. Two combinational read ports with same-cycle writeback bypass, a
// non-bypassed debug read port, a post-reset clear sequencer that walks the
// array one entry per cycle (so the storage has no reset and can map to RAM),
// a ready flag and a saturating committed-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              ready,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Last entry the clear sequencer touches; reaching it ends INIT.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
  // Register 1 is the first entry cleared; register 0 is never stored.
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic                r_ready;
  logic [CNT_W-1:0]    r_wr_count;

  // Storage array: no reset, single write port, so it stays RAM-friendly.
  logic [DATA_W-1:0]   r_mem [NREG];

  logic                w_run;
  logic                w_commit;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Per-port views of the two decode read ports so one generate body serves both.
  logic                w_re    [2];
  logic [ADDR_W-1:0]   w_raddr [2];
  logic [DATA_W-1:0]   w_rdata [2];

  assign w_run = (r_state == ST_RUN);

  // A writeback only commits in RUN and never to register 0.
  assign w_commit = w_run && wb_wreg && (wb_wd != '0);

  // The single write port is shared: the clear sequencer owns it during INIT,
  // the writeback path owns it in RUN. Reset edges leave the array untouched.
  assign w_mem_we    = !rst && (!w_run || w_commit);
  assign w_mem_addr  = w_run ? wb_wd : r_clr_idx;
  assign w_mem_wdata = w_run ? wb_wdata : '0;

  // Control FSM: clear sequencing, ready flag and committed-write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_clr_idx  <= FIRST_IDX;
      r_ready    <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_commit && (r_wr_count != CNT_MAX)) begin
            r_wr_count <= r_wr_count + 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Array write port: clear entries during INIT, committed writebacks in RUN.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_re[0]    = re1;
  assign w_raddr[0] = raddr1;
  assign w_re[1]    = re2;
  assign w_raddr[1] = raddr2;

  // Decode read ports: gated to zero until RUN, zero for register 0, and the
  // in-flight writeback is forwarded so decode sees it in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] w_val;

    // Per-port read mux with bypass priority over stored contents.
    always_comb begin
      w_val = '0;
      if (w_run && w_re[gi] && (w_raddr[gi] != '0)) begin
        if (wb_wreg && (wb_wd == w_raddr[gi])) begin
          w_val = wb_wdata;
        end else begin
          w_val = r_mem[w_raddr[gi]];
        end
      end
    end

    assign w_rdata[gi] = w_val;
  end

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];

  // Debug view shows committed contents only; nothing is forwarded here.
  assign dbg_data = (w_run && (dbg_addr != '0)) ? r_mem[dbg_addr] : '0;

  assign ready    = r_ready;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. The stimulus process drives one cycle at a
// time, pushes the expected outputs from a behavioural model, then advances
// the model across the clock edge. A separate monitor pops and compares.
// A second instance with a 4-bit counter shares the stimulus so that counter
// saturation is observed alongside the full-width counter.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [4:0]  dbg_addr;

  logic [31:0] rdata1, rdata2, dbg_data;
  logic        ready;
  logic [15:0] wr_count;

  logic [31:0] rdata1_s, rdata2_s, dbg_data_s;
  logic        ready_s;
  logic [3:0]  wr_count_s;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .ready(ready), .wr_count(wr_count)
  );

  wb_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_s),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_s),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_s),
    .ready(ready_s), .wr_count(wr_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
    logic        rdy;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Reference model: register values, edges elapsed since reset, write count.
  logic [31:0] m_regs [32];
  int          m_init_edges = 0;
  int          m_cnt        = 0;

  function automatic logic m_ready();
    return (m_init_edges >= 31);
  endfunction

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (!m_ready() || !en || a == 5'd0) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  // Drive one cycle, push the expected response, then step the model over the edge.
  task automatic cyc(input logic r, input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                     input logic [4:0] da);
    exp_t e;
    @(negedge clk);
    rst = r; wb_wreg = we; wb_wd = wd; wb_wdata = wdat;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2; dbg_addr = da;
    cyc_no++;
    e.rd1   = m_read(e1, a1);
    e.rd2   = m_read(e2, a2);
    e.dbg   = (m_ready() && da != 5'd0) ? m_regs[da] : 32'h0;
    e.rdy   = m_ready();
    e.cnt   = 16'(m_cnt > 65535 ? 65535 : m_cnt);
    e.cnt_s = 4'(m_cnt > 15 ? 15 : m_cnt);
    e.cyc   = cyc_no;
    sb_q.push_back(e);
    $display("cyc %0d rst=%0b we=%0b wd=%0d wdata=%h r1=%0b/%0d r2=%0b/%0d dbg=%0d exp_rd1=%h exp_rd2=%h exp_rdy=%0b exp_cnt=%0d",
             cyc_no, r, we, wd, wdat, e1, a1, e2, a2, da, e.rd1, e.rd2, e.rdy, e.cnt);
    @(posedge clk);
    if (r) begin
      m_init_edges = 0;
      m_cnt        = 0;
    end else if (!m_ready()) begin
      m_regs[m_init_edges + 1] = 32'h0;
      m_init_edges++;
    end else if (we && wd != 5'd0) begin
      m_regs[wd] = wdat;
      m_cnt++;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] a1);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, a1, 1'b0, 5'd0, a1);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata1",     rdata1,            e.rd1,           e.cyc);
        chk("rdata2",     rdata2,            e.rd2,           e.cyc);
        chk("dbg_data",   dbg_data,          e.dbg,           e.cyc);
        chk("ready",      {31'h0, ready},    {31'h0, e.rdy},  e.cyc);
        chk("wr_count",   {16'h0, wr_count}, {16'h0, e.cnt},  e.cyc);
        chk("wr_count_s", {28'h0, wr_count_s}, {28'h0, e.cnt_s}, e.cyc);
        chk("ready_s",    {31'h0, ready_s},  {31'h0, e.rdy},  e.cyc);
      end
    end
  end

  initial begin
    logic        r_we;
    logic [4:0]  r_wd, r_a1, r_a2;
    logic [31:0] r_dat;
    int          k;

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst = 1'b1; wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;

    // Reset for two cycles, then init; a writeback at init cycle 10 is ignored.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
    idle(9, 5'd7);
    cyc(1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd7, 1'b1, 5'd4, 5'd4);
    idle(23, 5'd7);
    idle(1, 5'd4);

    // Bypass on write to r5, then stored value and debug view.
    cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5);
    cyc(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b0, 5'd0, 5'd5);
    // Writes to r0 are discarded.
    cyc(1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
    // Overwrite r3 with a disabled second port, then enable it.
    cyc(1'b0, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    cyc(1'b0, 1'b1, 5'd3, 32'h2, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3);

    // Randomized traffic with rare resets.
    for (int i = 0; i < 1500; i++) begin
      r_we  = ($urandom_range(0, 9) < 7);
      r_wd  = 5'($urandom_range(0, 31));
      r_dat = $urandom;
      r_a1  = ($urandom_range(0, 2) == 0) ? r_wd : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 2) == 0) ? r_wd : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 399) == 0), r_we, r_wd, r_dat,
          ($urandom_range(0, 4) != 0), r_a1, ($urandom_range(0, 4) != 0), r_a2,
          5'($urandom_range(0, 31)));
    end

    // Reset, restart mid-init at cycle 15, and run a full init again.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
    idle(15, 5'd9);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
    idle(32, 5'd9);

    // Twenty committed writes: the 4-bit counter must stop at 15.
    for (int i = 0; i < 20; i++) begin
      k = (i % 31) + 1;
      cyc(1'b0, 1'b1, 5'(k), $urandom, 1'b1, 5'(k), 1'b1, 5'($urandom_range(0, 31)), 5'(k));
    end
    idle(2, 5'd1);

    // Drain the scoreboard within a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
